butterfly_r2: RTL and testbench
===============================

# butterfly_r2

Pipelined radix-2 FFT butterfly stage that consumes the sample pairs produced by the upstream pairing demultiplexer. It multiplies the second sample by a twiddle factor and forms the sum and difference. It then re-serialises the two results, sum first, onto a single complex output stream for the next FFT stage. It also drives the twiddle ROM address for each accepted pair.

## Interface
- `bit_width`, 16: data width of every real/imag sample, signed two's complement.
- `word_length_tw`, 14: twiddle width, signed Q1.(word_length_tw-2); 1.0 = 2^(word_length_tw-2) = 4096 at default.
- `N`, 1024: FFT points; twiddle index range 0..N/2-1; must be a power of two ≥ 4.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Re_i1`, `Im_i1` in bit_width: first sample A of pair.
- `Re_i2`, `Im_i2` in bit_width: second sample B of pair.
- `in_valid` in 1: pair valid, single-cycle strobe.
- `tw_addr` out log2(N/2): twiddle index for the next pair to be accepted.
- `cos_data`, `sin_data` in word_length_tw: twiddle from a registered ROM, valid the cycle after the pair is accepted.
- `Re_o`, `Im_o` out bit_width: serial result.
- `out_valid` out 1: result sample valid.
- `err_overrun` out 1: sticky pair-spacing violation flag.

## Operation
- Twiddle W = cos − j·sin.
- T = W·B:
  - Tr = Br·cos + Bi·sin.
  - Ti = Bi·cos − Br·sin.
- Products are full width, bit_width+word_length_tw.
- Tr and Ti are each rounded half-up: add 2^(word_length_tw-3), then arithmetic shift right by word_length_tw-2. Result is held at bit_width+2 bits.
- Sum X0 = A+T, difference X1 = A−T, both at bit_width+2 bits. Each is reduced to bit_width per Configuration.
- Pair acceptance:
  - A pair is accepted when in_valid=1 and in_valid was 0 in the previous cycle.
  - in_valid=1 for two consecutive cycles: the second pair is dropped, err_overrun is set to 1 and holds until reset.
- Twiddle counter:
  - On each accept, tw_addr increments.
  - It wraps from N/2−1 to 0.
  - The twiddle returned for a pair is the one addressed by the tw_addr value present in the accept cycle.
- Pipeline: a valid bit travels with each pair. Stages:
  - S1 captures A, B.
  - S2 registers the four products and sampled cos/sin.
  - S3 registers rounded Tr/Ti with delayed A.
  - S4 registers X0, X1.
- Serialiser, 2-state FSM:
  - IDLE: when S4 is valid, present X0, set out_valid=1, go to SECOND.
  - SECOND: present X1, out_valid=1. If a new S4 is valid in the same cycle, go to IDLE's output path directly, presenting the next X0 next cycle. Otherwise go to IDLE.
- Reset values: Re_o=0, Im_o=0, out_valid=0, tw_addr=0, err_overrun=0, all pipeline valid bits 0, FSM=IDLE.
- Reset asserted mid-operation discards all in-flight pairs. After release, no out_valid until a new pair has passed through the pipeline.

## Timing
- Edge E0 samples the accepted pair.
- X0 appears with out_valid=1 after edge E4 and X1 after edge E5.
- Latency is 4 cycles to the first sample.
- Pairs every 2 cycles (the upstream maximum rate) give continuous out_valid=1 with no gaps.
- The pipeline has no backpressure; the downstream stage must accept every out_valid sample.
- tw_addr updates on E0.

## Configuration
- `BFLY_SAT_EN` defined: X0 and X1 saturate to [−2^(bit_width-1), 2^(bit_width-1)−1].
- `BFLY_SAT_EN` undefined: X0 and X1 wrap by keeping the bit_width LSBs.
- Rounding is identical in both builds.

## Test plan
- W=1 (cos=4096, sin=0), A=(100,−50), B=(30,20) -> X0=(130,−30) after E4, X1=(70,−70) after E5; tw_addr 0→1.
- W=−j (cos=0, sin=4096), same A, B -> T=(20,−30), so X0=(120,−80), X1=(80,−20).
- Rounding: cos=2048, sin=0, A=0, B=(3,0) -> Tr=2 (1.5 rounds up), X0=(2,0), X1=(−2,0).
- Overflow: W=1, A=(30000,0), B=(10000,0) -> X0.re=32767 with BFLY_SAT_EN, −25536 without; X1.re=20000 in both builds.
- N=1024, 513 pairs spaced exactly 2 cycles -> out_valid continuous for 1026 cycles; tw_addr runs 0..511, wraps to 0 on pair 512, reads 1 after pair 513; err_overrun=0.
- in_valid high two consecutive cycles -> only the first pair is output, err_overrun=1 persists. Then assert rst_n=0 with a pair at S3 -> all outputs 0 and no out_valid after release.

Source files
------------

// File: rtl/butterfly_r2.sv
`timescale 1ns/1ps
// butterfly_r2 -- pipelined radix-2 FFT butterfly with serial output.
//
// Takes the pair (A, B) from the upstream pairing demux, multiplies B by
// the twiddle W = cos - j*sin, and forms X0 = A + W*B and X1 = A - W*B.
// The two results are re-serialised onto one complex stream, X0 first.
//
// Compile-time option:
//   BFLY_SAT_EN  defined   -> X0/X1 saturate to the bit_width signed range
//                undefined -> X0/X1 wrap (keep the bit_width LSBs)
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   Re_i1, Im_i1            sample A of the pair
//   Re_i2, Im_i2            sample B of the pair
//   in_valid                pair strobe; accepted on its rising edge only
//   tw_addr                 twiddle ROM index for the next accepted pair
//   cos_data, sin_data      twiddle from a registered ROM, one cycle after accept
//   Re_o, Im_o, out_valid   serial result stream (no backpressure)
//   err_overrun             sticky: in_valid was high two cycles in a row
//
// Handshake: in_valid is a strobe with no ready. A pair is taken only when
// in_valid rises; a strobe lasting more than one cycle drops the extra
// pairs and sets err_overrun. out_valid marks each output sample and the
// consumer must take every one.
module butterfly_r2 #(
    parameter int bit_width      = 16,
    parameter int word_length_tw = 14,
    parameter int N              = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [bit_width-1:0]        Re_i1,
    input  logic [bit_width-1:0]        Im_i1,
    input  logic [bit_width-1:0]        Re_i2,
    input  logic [bit_width-1:0]        Im_i2,
    input  logic                        in_valid,
    output logic [$clog2(N/2)-1:0]      tw_addr,
    input  logic [word_length_tw-1:0]   cos_data,
    input  logic [word_length_tw-1:0]   sin_data,
    output logic [bit_width-1:0]        Re_o,
    output logic [bit_width-1:0]        Im_o,
    output logic                        out_valid,
    output logic                        err_overrun
);

    localparam int AW    = $clog2(N/2);
    localparam int PW    = bit_width + word_length_tw;   // full product width
    localparam int SW    = PW + 1;                       // sum of two products
    localparam int RW    = bit_width + 2;                // rounded / butterfly width
    localparam int SHIFT = word_length_tw - 2;
    localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (word_length_tw - 3);

    // Reduce a butterfly output to bit_width.
    function automatic logic [bit_width-1:0] reduce(input logic signed [RW-1:0] x);
`ifdef BFLY_SAT_EN
        localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (bit_width - 1)) - 1);
        localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);
        if (x > SAT_MAX)
            return bit_width'(SAT_MAX);
        else if (x < SAT_MIN)
            return bit_width'(SAT_MIN);
        else
            return bit_width'(x);
`else
        return bit_width'(x);
`endif
    endfunction

    // ---------------- acceptance and twiddle counter ----------------
    logic in_valid_d;
    logic accept;

    assign accept = in_valid && !in_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_d  <= 1'b0;
            tw_addr     <= '0;
            err_overrun <= 1'b0;
        end else begin
            in_valid_d <= in_valid;
            // N/2 is a power of two, so the natural AW-bit wrap is N/2-1 -> 0.
            if (accept)
                tw_addr <= tw_addr + AW'(1);
            if (in_valid && in_valid_d)
                err_overrun <= 1'b1;
        end
    end

    // ---------------- pipeline registers ----------------
    logic                        s1_valid, s2_valid, s3_valid, s4_valid;
    logic [bit_width-1:0]        s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic [bit_width-1:0]        s2_a_re, s2_a_im;
    logic signed [PW-1:0]        s2_p_rc, s2_p_is, s2_p_ic, s2_p_rs;
    logic [bit_width-1:0]        s3_a_re, s3_a_im;
    logic signed [RW-1:0]        s3_tr, s3_ti;
    logic [bit_width-1:0]        s4_x0_re, s4_x0_im, s4_x1_re, s4_x1_im;

    logic signed [SW-1:0]        tr_full, ti_full;
    logic signed [RW-1:0]        x0_re, x0_im, x1_re, x1_im;

    // Round half-up: add half an LSB of the result, then arithmetic shift.
    always_comb begin
        tr_full = SW'(s2_p_rc) + SW'(s2_p_is) + RND;
        ti_full = SW'(s2_p_ic) - SW'(s2_p_rs) + RND;
    end

    always_comb begin
        x0_re = RW'($signed(s3_a_re)) + s3_tr;
        x0_im = RW'($signed(s3_a_im)) + s3_ti;
        x1_re = RW'($signed(s3_a_re)) - s3_tr;
        x1_im = RW'($signed(s3_a_im)) - s3_ti;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
            s2_p_rc  <= '0;
            s2_p_is  <= '0;
            s2_p_ic  <= '0;
            s2_p_rs  <= '0;
            s3_a_re  <= '0;
            s3_a_im  <= '0;
            s3_tr    <= '0;
            s3_ti    <= '0;
            s4_x0_re <= '0;
            s4_x0_im <= '0;
            s4_x1_re <= '0;
            s4_x1_im <= '0;
        end else begin
            // S1: capture the pair on the accept edge
            s1_valid <= accept;
            if (accept) begin
                s1_a_re <= Re_i1;
                s1_a_im <= Im_i1;
                s1_b_re <= Re_i2;
                s1_b_im <= Im_i2;
            end
            // S2: twiddle arrives from the ROM this cycle; form all four products
            s2_valid <= s1_valid;
            s2_a_re  <= s1_a_re;
            s2_a_im  <= s1_a_im;
            s2_p_rc  <= PW'($signed(s1_b_re)) * PW'($signed(cos_data));
            s2_p_is  <= PW'($signed(s1_b_im)) * PW'($signed(sin_data));
            s2_p_ic  <= PW'($signed(s1_b_im)) * PW'($signed(cos_data));
            s2_p_rs  <= PW'($signed(s1_b_re)) * PW'($signed(sin_data));
            // S3: rounded T = W*B
            s3_valid <= s2_valid;
            s3_a_re  <= s2_a_re;
            s3_a_im  <= s2_a_im;
            s3_tr    <= RW'(tr_full >>> SHIFT);
            s3_ti    <= RW'(ti_full >>> SHIFT);
            // S4: sum and difference, reduced to bit_width
            s4_valid <= s3_valid;
            s4_x0_re <= reduce(x0_re);
            s4_x0_im <= reduce(x0_im);
            s4_x1_re <= reduce(x1_re);
            s4_x1_im <= reduce(x1_im);
        end
    end

    // ---------------- serialiser ----------------
    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [bit_width-1:0] hold_re, hold_im, hold_re_next, hold_im_next;
    logic [bit_width-1:0] re_next, im_next;
    logic                 valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_re   <= '0;
            hold_im   <= '0;
            Re_o      <= '0;
            Im_o      <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            hold_re   <= hold_re_next;
            hold_im   <= hold_im_next;
            Re_o      <= re_next;
            Im_o      <= im_next;
            out_valid <= valid_next;
        end
    end

    // X1 is parked in hold_* because S4 is overwritten the cycle after it
    // is valid. Accepted pairs are at least two cycles apart, so S4 is never
    // valid while SECOND is draining X1; a pair arriving every second cycle
    // reaches S4 exactly as SECOND returns to IDLE, giving a gap-free stream.
    always_comb begin
        state_next   = state;
        hold_re_next = hold_re;
        hold_im_next = hold_im;
        re_next      = '0;
        im_next      = '0;
        valid_next   = 1'b0;
        case (state)
            IDLE: begin
                if (s4_valid) begin
                    re_next      = s4_x0_re;
                    im_next      = s4_x0_im;
                    valid_next   = 1'b1;
                    hold_re_next = s4_x1_re;
                    hold_im_next = s4_x1_im;
                    state_next   = SECOND;
                end
            end
            SECOND: begin
                re_next    = hold_re;
                im_next    = hold_im;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_butterfly_r2.sv
`timescale 1ns/1ps
module tb_butterfly_r2;
    localparam int BW = 16;
    localparam int TW = 14;
    localparam int NP = 1024;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] Re_i1, Im_i1, Re_i2, Im_i2;
    logic          in_valid;
    logic [AW-1:0] tw_addr;
    logic [TW-1:0] cos_data, sin_data;
    logic [BW-1:0] Re_o, Im_o;
    logic          out_valid;
    logic          err_overrun;

    butterfly_r2 #(.bit_width(BW), .word_length_tw(TW), .N(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
        .in_valid(in_valid), .tw_addr(tw_addr),
        .cos_data(cos_data), .sin_data(sin_data),
        .Re_o(Re_o), .Im_o(Im_o), .out_valid(out_valid),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [2*BW-1:0] exp_q[$];
    logic [2*BW-1:0] exp_word;
    int              run_len  = 0;
    int              last_run = 0;
    int              n_acc    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pair(input int x0r, input int x0i, input int x1r, input int x1i);
        exp_q.push_back({BW'(x0r), BW'(x0i)});
        exp_q.push_back({BW'(x1r), BW'(x1i)});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_word = exp_q.pop_front();
                check("out_sample", {Re_o, Im_o}, exp_word);
            end
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    // ---------------- driver ----------------
    // One pair per two cycles: strobe for one cycle, then present the twiddle.
    task automatic apply_pair(input int ar, input int ai, input int br, input int bi,
                              input int c, input int s);
        @(negedge clk);
        Re_i1 = BW'(ar); Im_i1 = BW'(ai);
        Re_i2 = BW'(br); Im_i2 = BW'(bi);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cos_data = TW'(c);
        sin_data = TW'(s);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_re_o"}, Re_o, 0);
        check({tag, "_im_o"}, Im_o, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_tw_addr"}, tw_addr, 0);
        check({tag, "_err_overrun"}, err_overrun, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int ar, ai, br, bi, c, s;
        int x0r, x0i, x1r, x1i;
    } vec_t;

    vec_t vecs[9];
    int   seen;

    initial begin
`ifdef BFLY_SAT_EN
        vecs[3] = '{30000, 0, 10000, 0, 4096, 0, 32767, 0, 20000, 0};
        vecs[8] = '{-30000, 0, 10000, 0, 4096, 0, -20000, 0, -32768, 0};
`else
        vecs[3] = '{30000, 0, 10000, 0, 4096, 0, -25536, 0, 20000, 0};
        vecs[8] = '{-30000, 0, 10000, 0, 4096, 0, -20000, 0, 25536, 0};
`endif
        vecs[0] = '{100, -50, 30, 20, 4096, 0, 130, -30, 70, -70};
        vecs[1] = '{100, -50, 30, 20, 0, 4096, 120, -80, 80, -20};
        vecs[2] = '{0, 0, 3, 0, 2048, 0, 2, 0, -2, 0};
        vecs[4] = '{1000, 2000, 300, -400, -4096, 0, 700, 2400, 1300, 1600};
        vecs[5] = '{0, 0, -3, 0, 2048, 0, -1, 0, 1, 0};
        vecs[6] = '{0, 0, 0, 5, 2048, 0, 0, 3, 0, -3};
        vecs[7] = '{0, 0, 1000, 0, 2896, 2896, 707, -707, -707, 707};

        Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0;
        in_valid = 1'b0; cos_data = '0; sin_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, back to back at the maximum pair rate
        for (int i = 0; i < 9; i++) begin
            check("tw_addr_vec", tw_addr, n_acc % (NP/2));
            push_pair(vecs[i].x0r, vecs[i].x0i, vecs[i].x1r, vecs[i].x1i);
            apply_pair(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, vecs[i].c, vecs[i].s);
            n_acc++;
        end
        drain();
        check("err_after_vectors", err_overrun, 0);

        // Latency: X0 after E4, X1 after E5, nothing before or after
        push_pair(130, -30, 70, -70);
        apply_pair(100, -50, 30, 20, 4096, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("latency_valid", out_valid, (c == 4 || c == 5) ? 1 : 0);
        end
        repeat (3) @(negedge clk);

        // Fresh reset, then 513 pairs at 2-cycle spacing
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 513; k++) begin
            check("tw_addr_run", tw_addr, k % (NP/2));
            push_pair(k + (k % 7), -k + 3, k - (k % 7), -k - 3);
            apply_pair(k, -k, k % 7, 3, 4096, 0);
        end
        check("tw_addr_after_run", tw_addr, 1);
        drain();
        check("continuous_run_len", last_run, 1026);
        check("err_after_run", err_overrun, 0);

        // Overrun: in_valid high two cycles, second pair must be dropped
        push_pair(600, 0, 400, 0);
        @(negedge clk);
        Re_i1 = BW'(500); Im_i1 = '0; Re_i2 = BW'(100); Im_i2 = '0;
        in_valid = 1'b1;
        @(negedge clk);
        Re_i1 = BW'(7); Im_i1 = BW'(7); Re_i2 = BW'(9); Im_i2 = BW'(9);
        cos_data = TW'(4096); sin_data = '0;
        @(negedge clk);
        in_valid = 1'b0;
        check("err_overrun_set", err_overrun, 1);
        check("tw_addr_overrun", tw_addr, 2);
        drain();
        check("err_overrun_sticky", err_overrun, 1);

        // Reset while a pair sits in S3
        apply_pair(1000, 1000, 10, 10, 4096, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_reset_valid", seen, 0);
        check("queue_empty_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
